sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for the EVR delay-compensation path and other same-clock buffering. It replaces hard-primitive FIFO instantiation with inferred RAM plus control logic. Width and depth are arbitrary (depth a power of two). It adds selectable first-word-fall-through, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags and a synchronous flush.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/sdp_ram.sv | 43 ++++
 rtl/sync_fifo.sv | 151 +++++++++++++++
 tb/tb_sync_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the sync_fifo slice: pointer sizing and parameter sanity checks.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int aempty, input int afull);
        return (aempty < afull) && (afull <= depth);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the read register clears.
module sdp_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rd_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_rst) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with inferred RAM, optional first-word-fall-through,
// occupancy count, programmable almost flags and sticky overflow/underflow.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter int WIDTH         = 32,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic [WIDTH-1:0]          d_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          d_out,
    output logic                      d_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 4");
    end
    if (!thresh_ok(DEPTH, AEMPTY_THRESH, AFULL_THRESH)) begin : g_bad_thresh
        $fatal(1, "sync_fifo: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo: WIDTH must be at least 1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             dvalid_q, dvalid_d;
    logic             byp_sel_q, byp_sel_d;
    logic [WIDTH-1:0] byp_q, byp_d;

    logic             flush;
    logic             wr_ok;
    logic             rd_ok;
    logic             ram_empty;
    logic             bypass;
    logic             ram_wr;
    logic             ram_rd;
    logic [WIDTH-1:0] ram_rdata;

    // In FWFT mode the head word lives in the output stage, so the RAM only
    // holds words behind it; a write lands in the bypass register whenever
    // the output stage would otherwise be left without a word.
    always_comb begin
        flush     = !rst_n || clr;
        wr_ok     = wr_en && !full_q;
        rd_ok     = rd_en && !empty_q;
        ram_empty = (wr_ptr_q == rd_ptr_q);
        if (FWFT != 0) begin
            bypass = wr_ok && (empty_q || (rd_ok && ram_empty));
            ram_wr = wr_ok && !bypass;
            ram_rd = rd_ok && !ram_empty;
        end else begin
            bypass = 1'b0;
            ram_wr = wr_ok;
            ram_rd = rd_ok;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(ram_wr);
        rd_ptr_d  = rd_ptr_q + PW'(ram_rd);
        count_d   = count_q + PW'(wr_ok) - PW'(rd_ok);
        byp_d     = bypass ? d_in : byp_q;
        byp_sel_d = bypass ? 1'b1 : (ram_rd ? 1'b0 : byp_sel_q);
        ovf_d     = ovf_q | (wr_en && full_q);
        udf_d     = udf_q | (rd_en && empty_q);
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            byp_d     = '0;
            byp_sel_d = 1'b0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end
        full_d   = (count_d == PW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (int'(count_d) >= AFULL_THRESH);
        aempty_d = (int'(count_d) <= AEMPTY_THRESH);
        if (FWFT != 0) begin
            dvalid_d = !empty_d;
        end else begin
            dvalid_d = rd_ok && !flush;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        count_q   <= count_d;
        full_q    <= full_d;
        empty_q   <= empty_d;
        afull_q   <= afull_d;
        aempty_q  <= aempty_d;
        ovf_q     <= ovf_d;
        udf_q     <= udf_d;
        dvalid_q  <= dvalid_d;
        byp_sel_q <= byp_sel_d;
        byp_q     <= byp_d;
    end

    sdp_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .rd_rst  (flush),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (d_in),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rdata)
    );

    assign d_out        = byp_sel_q ? byp_q : ram_rdata;
    assign d_valid      = dvalid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard and an FWFT instance share one stimulus
// stream and are both compared against a queue-based reference model.
module tb_sync_fifo;

    localparam int D = 16;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic clr;
    logic wr_en;
    logic rd_en;
    logic [W-1:0] d_in;

    logic [W-1:0] s_d_out, f_d_out;
    logic s_d_valid, f_d_valid, s_full, f_full, s_empty, f_empty;
    logic s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
    logic [4:0] s_count, f_count;

    sync_fifo #(.DEPTH(D), .WIDTH(W), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .d_in(d_in), .wr_en(wr_en), .rd_en(rd_en),
        .d_out(s_d_out), .d_valid(s_d_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo #(.DEPTH(D), .WIDTH(W), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .d_in(d_in), .wr_en(wr_en), .rd_en(rd_en),
        .d_out(f_d_out), .d_valid(f_d_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: occupancy is the queue, sticky flags and last read word.
    logic [W-1:0] q[$];
    logic [W-1:0] e_dout = '0;
    logic         e_dv   = 1'b0;
    logic         e_ovf  = 1'b0;
    logic         e_udf  = 1'b0;

    task automatic model_step(input logic w, input logic r, input logic [W-1:0] din);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (!rst_n || clr) begin
            q.delete();
            e_dout = '0;
            e_dv   = 1'b0;
            e_ovf  = 1'b0;
            e_udf  = 1'b0;
        end else begin
            e_dv = 1'b0;
            if (r && !was_empty) begin
                e_dout = q.pop_front();
                e_dv   = 1'b1;
            end
            if (w && !was_full) q.push_back(din);
            if (w && was_full)  e_ovf = 1'b1;
            if (r && was_empty) e_udf = 1'b1;
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [W-1:0] din);
        wr_en = w;
        rd_en = r;
        d_in  = din;
        model_step(w, r, din);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 8'h3C);
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_d_out !== 8'h00) begin n_fail++; $display("FAIL reset_s_dout got %h exp 00", s_d_out); end
        n_checks++; if (f_d_out !== 8'h00) begin n_fail++; $display("FAIL reset_f_dout got %h exp 00", f_d_out); end
        n_checks++; if (s_d_valid !== 1'b0 || f_d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid got %b/%b exp 0/0", s_d_valid, f_d_valid); end
        n_checks++; if (s_full !== 1'b0 || f_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b/%b exp 0/0", s_full, f_full); end
        n_checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b/%b exp 1/1", s_empty, f_empty); end
        n_checks++; if (s_af !== 1'b0 || f_af !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b/%b exp 0/0", s_af, f_af); end
        n_checks++; if (s_ae !== 1'b1 || f_ae !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b/%b exp 1/1", s_ae, f_ae); end
        n_checks++; if (s_count !== 5'd0 || f_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d/%0d exp 0/0", s_count, f_count); end
        n_checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
            n_fail++; $display("FAIL reset_sticky got %b%b%b%b exp 0000", s_ovf, s_udf, f_ovf, f_udf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            n_checks++; if (s_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, s_count, i + 1); end
            n_checks++; if (s_full !== (i == D - 1)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, s_full, (i == D - 1)); end
            n_checks++; if (s_af !== (i + 1 >= 12)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, s_af, (i + 1 >= 12)); end
            n_checks++; if (f_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_fcount[%0d] got %0d exp %0d", i, f_count, i + 1); end
        end
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++; if (s_d_valid !== 1'b1) begin n_fail++; $display("FAIL drain_dvalid[%0d] got %b exp 1", i, s_d_valid); end
            n_checks++; if (s_d_out !== 8'(i)) begin n_fail++; $display("FAIL drain_dout[%0d] got %h exp %h", i, s_d_out, 8'(i)); end
            cyc(1'b0, 1'b0, 8'h00);
            n_checks++; if (s_d_valid !== 1'b0) begin n_fail++; $display("FAIL drain_pulse[%0d] got %b exp 0", i, s_d_valid); end
            n_checks++; if (s_d_out !== 8'(i)) begin n_fail++; $display("FAIL drain_hold[%0d] got %h exp %h", i, s_d_out, 8'(i)); end
        end
        n_checks++; if (s_empty !== 1'b1 || s_count !== 5'd0) begin n_fail++; $display("FAIL drain_empty got %b/%0d exp 1/0", s_empty, s_count); end
    endtask

    task automatic test_overflow_underflow;
        logic [W-1:0] held;
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 8'($urandom));
        n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b exp 0", s_ovf); end
        cyc(1'b1, 1'b0, 8'hEE);
        n_checks++; if (s_count !== 5'd16 || f_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d/%0d exp 16", s_count, f_count); end
        n_checks++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b/%b exp 1/1", s_ovf, f_ovf); end
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", s_ovf); end
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++; if (s_d_out !== e_dout) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, s_d_out, e_dout); end
        end
        held = e_dout;
        n_checks++; if (s_udf !== 1'b0) begin n_fail++; $display("FAIL udf_pre got %b exp 0", s_udf); end
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++; if (s_udf !== 1'b1 || f_udf !== 1'b1) begin n_fail++; $display("FAIL udf_set got %b/%b exp 1/1", s_udf, f_udf); end
        n_checks++; if (s_d_out !== held) begin n_fail++; $display("FAIL udf_dout_hold got %h exp %h", s_d_out, held); end
        n_checks++; if (s_d_valid !== 1'b0) begin n_fail++; $display("FAIL udf_dvalid got %b exp 0", s_d_valid); end
        n_checks++; if (s_count !== 5'd0) begin n_fail++; $display("FAIL udf_count got %0d exp 0", s_count); end
    endtask

    task automatic test_fwft_single;
        cyc(1'b1, 1'b0, 8'hA5);
        n_checks++; if (f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft1_empty got %b exp 0", f_empty); end
        n_checks++; if (f_d_out !== 8'hA5) begin n_fail++; $display("FAIL fwft1_dout got %h exp a5", f_d_out); end
        n_checks++; if (f_d_valid !== 1'b1 || f_count !== 5'd1) begin n_fail++; $display("FAIL fwft1_state got %b/%0d exp 1/1", f_d_valid, f_count); end
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++; if (f_d_out !== 8'hA5 || f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft1_hold got %h/%b exp a5/0", f_d_out, f_empty); end
        cyc(1'b0, 1'b1, 8'h00);
        n_checks++; if (f_empty !== 1'b1 || f_d_valid !== 1'b0) begin n_fail++; $display("FAIL fwft1_pop got %b/%b exp 1/0", f_empty, f_d_valid); end
    endtask

    task automatic test_fwft_stream;
        logic [W-1:0] w [3];
        for (int i = 0; i < 3; i++) begin
            w[i] = 8'($urandom);
            cyc(1'b1, 1'b0, w[i]);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (f_d_out !== w[i] || f_d_valid !== 1'b1) begin
                n_fail++; $display("FAIL fwft_stream[%0d] got %h/%b exp %h/1", i, f_d_out, f_d_valid, w[i]);
            end
            cyc(1'b0, 1'b1, 8'h00);
            n_checks++; if (s_d_out !== w[i]) begin n_fail++; $display("FAIL std_stream[%0d] got %h exp %h", i, s_d_out, w[i]); end
        end
        n_checks++; if (f_empty !== 1'b1 || f_d_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_stream_end got %b/%b exp 1/0", f_empty, f_d_valid); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 8'($urandom));
            n_checks++; if (s_count !== 5'd5 || f_count !== 5'd5) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d/%0d exp 5", i, s_count, f_count); end
            n_checks++; if (s_d_out !== e_dout || s_d_valid !== 1'b1) begin
                n_fail++; $display("FAIL wrap_std[%0d] got %h/%b exp %h/1", i, s_d_out, s_d_valid, e_dout);
            end
            n_checks++; if (f_d_out !== q[0]) begin n_fail++; $display("FAIL wrap_fwft[%0d] got %h exp %h", i, f_d_out, q[0]); end
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_random;
        int wp;
        int rp;
        for (int i = 0; i < 400; i++) begin
            wp = (i < 200) ? 70 : 35;
            rp = (i < 200) ? 35 : 70;
            clr = ($urandom_range(0, 99) == 0);
            cyc(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), 8'($urandom));
            clr = 1'b0;
            n_checks++; if (s_count !== 5'(q.size()) || f_count !== 5'(q.size())) begin
                n_fail++; $display("FAIL rand_count[%0d] got %0d/%0d exp %0d", i, s_count, f_count, q.size());
            end
            n_checks++; if (s_full !== (q.size() == D) || f_full !== (q.size() == D)) begin
                n_fail++; $display("FAIL rand_full[%0d] got %b/%b exp %b", i, s_full, f_full, (q.size() == D));
            end
            n_checks++; if (s_empty !== (q.size() == 0) || f_empty !== (q.size() == 0)) begin
                n_fail++; $display("FAIL rand_empty[%0d] got %b/%b exp %b", i, s_empty, f_empty, (q.size() == 0));
            end
            n_checks++; if (s_af !== (q.size() >= 12) || f_ae !== (q.size() <= 4) || s_ae !== (q.size() <= 4)) begin
                n_fail++; $display("FAIL rand_almost[%0d] got af %b ae %b/%b size %0d", i, s_af, s_ae, f_ae, q.size());
            end
            n_checks++; if (s_ovf !== e_ovf || s_udf !== e_udf || f_ovf !== e_ovf || f_udf !== e_udf) begin
                n_fail++; $display("FAIL rand_sticky[%0d] got %b%b%b%b exp %b%b", i, s_ovf, s_udf, f_ovf, f_udf, e_ovf, e_udf);
            end
            n_checks++; if (s_d_valid !== e_dv || s_d_out !== e_dout) begin
                n_fail++; $display("FAIL rand_std_read[%0d] got %h/%b exp %h/%b", i, s_d_out, s_d_valid, e_dout, e_dv);
            end
            n_checks++; if (f_d_valid !== (q.size() != 0) || (q.size() != 0 && f_d_out !== q[0])) begin
                n_fail++; $display("FAIL rand_fwft_head[%0d] got %h/%b size %0d", i, f_d_out, f_d_valid, q.size());
            end
        end
    endtask

    task automatic setup_half;
        for (int i = 0; i <= D; i++) cyc(1'b0, 1'b1, 8'h00);
        for (int i = 0; i <= D; i++) cyc(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < D / 2; i++) cyc(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_clr_mid;
        setup_half();
        n_checks++; if (s_count !== 5'd8 || s_ovf !== 1'b1 || s_udf !== 1'b1) begin
            n_fail++; $display("FAIL clr_setup got %0d/%b/%b exp 8/1/1", s_count, s_ovf, s_udf);
        end
        clr = 1'b1;
        cyc(1'b1, 1'b1, 8'h77);
        clr = 1'b0;
        n_checks++; if (s_count !== 5'd0 || f_count !== 5'd0) begin n_fail++; $display("FAIL clr_count got %0d/%0d exp 0", s_count, f_count); end
        n_checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b/%b exp 1", s_empty, f_empty); end
        n_checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
            n_fail++; $display("FAIL clr_sticky got %b%b%b%b exp 0000", s_ovf, s_udf, f_ovf, f_udf);
        end
        n_checks++; if (s_d_valid !== 1'b0 || s_d_out !== 8'h00) begin n_fail++; $display("FAIL clr_read got %h/%b exp 00/0", s_d_out, s_d_valid); end
    endtask

    task automatic test_rst_mid;
        setup_half();
        n_checks++; if (f_count !== 5'd8 || f_ovf !== 1'b1 || f_udf !== 1'b1) begin
            n_fail++; $display("FAIL rst_setup got %0d/%b/%b exp 8/1/1", f_count, f_ovf, f_udf);
        end
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 8'h55);
        rst_n = 1'b1;
        n_checks++; if (s_count !== 5'd0 || f_count !== 5'd0) begin n_fail++; $display("FAIL rst_count got %0d/%0d exp 0", s_count, f_count); end
        n_checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1 || s_ae !== 1'b1) begin
            n_fail++; $display("FAIL rst_empty got %b/%b/%b exp 1", s_empty, f_empty, s_ae);
        end
        n_checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
            n_fail++; $display("FAIL rst_sticky got %b%b%b%b exp 0000", s_ovf, s_udf, f_ovf, f_udf);
        end
        cyc(1'b1, 1'b0, 8'h3A);
        n_checks++; if (f_d_out !== 8'h3A || s_count !== 5'd1) begin
            n_fail++; $display("FAIL rst_resume got %h/%0d exp 3a/1", f_d_out, s_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d_in  = '0;
        #1;
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_fwft_single();
        test_fwft_stream();
        test_wrap();
        test_random();
        test_clr_mid();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
